// File: rtl/ttt_game_ctrl.sv
// Tic-tac-toe game sequencer: takes keypad cell strobes, keeps the 3x3 board,
// alternates turns and flags win/draw for the display and board-LED logic.
module ttt_game_ctrl #(
    parameter logic FIRST_PLAYER = 1'b0
) (
    input  logic       clk_10000Hz,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic       new_game,
    output logic       whosTurn,
    output logic [1:0] gameend,
    output logic [8:0] board_o,
    output logic [8:0] board_x,
    output logic [3:0] move_count,
    output logic       illegal_move
);

    typedef enum logic [1:0] {StPlay, StCheck, StEnd} state_e;

    state_e     state_q, state_d;
    logic       turn_q, turn_d;
    logic [1:0] gameend_q, gameend_d;
    logic [8:0] board_o_q, board_o_d;
    logic [8:0] board_x_q, board_x_d;
    logic [3:0] count_q, count_d;
    logic       illegal_q, illegal_d;

    logic       key_in_range;
    logic [8:0] key_mask;
    logic [8:0] mover_board;

    // True when the bitmap covers any of the 8 winning lines.
    function automatic logic has_line(input logic [8:0] b);
        return (&{b[0], b[1], b[2]}) || (&{b[3], b[4], b[5]}) || (&{b[6], b[7], b[8]}) ||
               (&{b[0], b[3], b[6]}) || (&{b[1], b[4], b[7]}) || (&{b[2], b[5], b[8]}) ||
               (&{b[0], b[4], b[8]}) || (&{b[2], b[4], b[6]});
    endfunction

    // Decode the key into a one-hot cell mask; out-of-range codes yield no cell.
    always_comb begin
        key_in_range = (key_code <= 4'd8);
        key_mask     = key_in_range ? (9'd1 << key_code) : 9'd0;
        mover_board  = turn_q ? board_x_q : board_o_q;
    end

    // Next-state and output computation; new_game overrides everything, including a key.
    always_comb begin
        state_d   = state_q;
        turn_d    = turn_q;
        gameend_d = gameend_q;
        board_o_d = board_o_q;
        board_x_d = board_x_q;
        count_d   = count_q;
        illegal_d = 1'b0;

        if (new_game) begin
            state_d   = StPlay;
            turn_d    = FIRST_PLAYER;
            gameend_d = 2'b00;
            board_o_d = 9'd0;
            board_x_d = 9'd0;
            count_d   = 4'd0;
        end else begin
            unique case (state_q)
                StPlay: begin
                    if (key_valid) begin
                        if (key_in_range && ((key_mask & (board_o_q | board_x_q)) == 9'd0)) begin
                            if (turn_q) board_x_d = board_x_q | key_mask;
                            else        board_o_d = board_o_q | key_mask;
                            count_d = count_q + 4'd1;
                            state_d = StCheck;
                        end else begin
                            illegal_d = 1'b1;
                        end
                    end
                end
                StCheck: begin
                    // Win is checked before draw so a winning 9th move is a win.
                    if (has_line(mover_board)) begin
                        gameend_d = turn_q ? 2'b10 : 2'b01;
                        state_d   = StEnd;
                    end else if (count_q == 4'd9) begin
                        gameend_d = 2'b11;
                        state_d   = StEnd;
                    end else begin
                        turn_d  = ~turn_q;
                        state_d = StPlay;
                    end
                end
                StEnd: begin
                    state_d = StEnd;
                end
                default: begin
                    state_d = StPlay;
                end
            endcase
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk_10000Hz or negedge reset) begin
        if (!reset) begin
            state_q   <= StPlay;
            turn_q    <= FIRST_PLAYER;
            gameend_q <= 2'b00;
            board_o_q <= 9'd0;
            board_x_q <= 9'd0;
            count_q   <= 4'd0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            turn_q    <= turn_d;
            gameend_q <= gameend_d;
            board_o_q <= board_o_d;
            board_x_q <= board_x_d;
            count_q   <= count_d;
            illegal_q <= illegal_d;
        end
    end

    assign whosTurn     = turn_q;
    assign gameend      = gameend_q;
    assign board_o      = board_o_q;
    assign board_x      = board_x_q;
    assign move_count   = count_q;
    assign illegal_move = illegal_q;

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// Directed bench for the tic-tac-toe sequencer.
module tb_ttt_game_ctrl;

    logic       clk_10000Hz;
    logic       reset;
    logic       key_valid;
    logic [3:0] key_code;
    logic       new_game;
    logic       whosTurn;
    logic [1:0] gameend;
    logic [8:0] board_o;
    logic [8:0] board_x;
    logic [3:0] move_count;
    logic       illegal_move;

    int vectors;
    int miscompares;

    ttt_game_ctrl #(.FIRST_PLAYER(1'b0)) dut (
        .clk_10000Hz (clk_10000Hz),
        .reset       (reset),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .new_game    (new_game),
        .whosTurn    (whosTurn),
        .gameend     (gameend),
        .board_o     (board_o),
        .board_x     (board_x),
        .move_count  (move_count),
        .illegal_move(illegal_move)
    );

    initial clk_10000Hz = 1'b0;
    always #5 clk_10000Hz = ~clk_10000Hz;

    task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %b, expected %b", tag, obs, exp);
        end
    endtask

    // Present one key for a single edge; returns on the following falling edge.
    task automatic press(input logic [3:0] k);
        @(negedge clk_10000Hz);
        key_valid = 1'b1;
        key_code  = k;
        @(negedge clk_10000Hz);
        key_valid = 1'b0;
        key_code  = 4'd0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_10000Hz);
    endtask

    // Key followed by two idle cycles so the check step completes.
    task automatic move(input logic [3:0] k);
        press(k);
        idle(2);
    endtask

    task automatic restart();
        @(negedge clk_10000Hz);
        new_game = 1'b1;
        @(negedge clk_10000Hz);
        new_game = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b0;
        key_valid   = 1'b0;
        key_code    = 4'd0;
        new_game    = 1'b0;

        // T1: reset values, then an async reset mid-game
        #12;
        check("rst_turn", 9'(whosTurn), 9'd0);
        check("rst_gameend", 9'(gameend), 9'd0);
        check("rst_board_o", board_o, 9'd0);
        check("rst_board_x", board_x, 9'd0);
        check("rst_count", 9'(move_count), 9'd0);
        check("rst_illegal", 9'(illegal_move), 9'd0);
        @(negedge clk_10000Hz);
        reset = 1'b1;
        move(4'd4);
        check("t1_pre_board_o", board_o, 9'b000010000);
        check("t1_pre_turn", 9'(whosTurn), 9'd1);
        #2 reset = 1'b0;
        #1;
        check("t1_async_board_o", board_o, 9'd0);
        check("t1_async_count", 9'(move_count), 9'd0);
        check("t1_async_turn", 9'(whosTurn), 9'd0);
        @(negedge clk_10000Hz);
        reset = 1'b1;
        idle(1);
        check("t1_release_turn", 9'(whosTurn), 9'd0);

        // T2: O completes the top row
        move(4'd0);
        move(4'd3);
        move(4'd1);
        move(4'd4);
        press(4'd2);
        check("t2_board_o_visible", board_o, 9'b000000111);
        check("t2_gameend_pending", 9'(gameend), 9'd0);
        @(negedge clk_10000Hz);
        check("t2_gameend", 9'(gameend), 9'b01);
        check("t2_turn", 9'(whosTurn), 9'd0);
        check("t2_board_x", board_x, 9'b000011000);
        check("t2_count", 9'(move_count), 9'd5);
        press(4'd8);
        check("t2_end_ignore_illegal", 9'(illegal_move), 9'd0);
        idle(1);
        check("t2_end_ignore_board_o", board_o, 9'b000000111);
        check("t2_end_ignore_count", 9'(move_count), 9'd5);

        // T3: X anti-diagonal win
        restart();
        check("t3_cleared_gameend", 9'(gameend), 9'd0);
        check("t3_cleared_board_o", board_o, 9'd0);
        move(4'd0);
        move(4'd2);
        move(4'd1);
        move(4'd4);
        move(4'd8);
        move(4'd6);
        check("t3_gameend", 9'(gameend), 9'b10);
        check("t3_board_x", board_x, 9'b001010100);
        check("t3_count", 9'(move_count), 9'd6);
        check("t3_turn", 9'(whosTurn), 9'd1);

        // T4: draw
        restart();
        move(4'd0);
        move(4'd1);
        move(4'd2);
        move(4'd4);
        move(4'd3);
        move(4'd5);
        move(4'd7);
        move(4'd6);
        move(4'd8);
        check("t4_gameend", 9'(gameend), 9'b11);
        check("t4_count", 9'(move_count), 9'd9);
        check("t4_board_o", board_o, 9'b110001101);
        check("t4_board_x", board_x, 9'b001110010);
        check("t4_turn", 9'(whosTurn), 9'd0);

        // T5: occupied cell and out-of-range key
        restart();
        move(4'd4);
        check("t5_turn_after_o", 9'(whosTurn), 9'd1);
        press(4'd4);
        check("t5_occupied_pulse", 9'(illegal_move), 9'd1);
        idle(1);
        check("t5_occupied_pulse_end", 9'(illegal_move), 9'd0);
        press(4'd12);
        check("t5_range_pulse", 9'(illegal_move), 9'd1);
        idle(1);
        check("t5_range_pulse_end", 9'(illegal_move), 9'd0);
        check("t5_board_x", board_x, 9'd0);
        check("t5_turn", 9'(whosTurn), 9'd1);
        check("t5_count", 9'(move_count), 9'd1);

        // T6: key during the check cycle, then new_game colliding with a key
        @(negedge clk_10000Hz);
        key_valid = 1'b1;
        key_code  = 4'd0;
        @(negedge clk_10000Hz);
        key_code  = 4'd1;
        @(negedge clk_10000Hz);
        key_valid = 1'b0;
        check("t6_check_ignore_board_x", board_x, 9'b000000001);
        check("t6_check_ignore_illegal", 9'(illegal_move), 9'd0);
        check("t6_check_ignore_count", 9'(move_count), 9'd2);
        check("t6_check_turn", 9'(whosTurn), 9'd0);
        idle(1);
        new_game  = 1'b1;
        key_valid = 1'b1;
        key_code  = 4'd5;
        @(negedge clk_10000Hz);
        new_game  = 1'b0;
        key_valid = 1'b0;
        check("t6_ng_board_o", board_o, 9'd0);
        check("t6_ng_board_x", board_x, 9'd0);
        check("t6_ng_count", 9'(move_count), 9'd0);
        check("t6_ng_turn", 9'(whosTurn), 9'd0);
        check("t6_ng_illegal", 9'(illegal_move), 9'd0);
        press(4'd5);
        check("t6_after_ng_board_o", board_o, 9'b000100000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
